// File: rtl/multi_dataflow_kernel_tracker_if.sv
// rtl/multi_dataflow_kernel_tracker_if.sv - handshake, quota and flag bundle for the kernel tracker
interface multi_dataflow_kernel_tracker_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 1,
    parameter int unsigned CNT_W = 16
);
    logic                   start_i;
    logic [N_IN-1:0]        in_valid_i;
    logic [N_IN-1:0]        in_ready_i;
    logic [N_OUT-1:0]       out_valid_i;
    logic [N_OUT-1:0]       out_ready_i;
    logic [N_IN*CNT_W-1:0]  in_quota_i;
    logic [N_OUT*CNT_W-1:0] out_quota_i;
    logic                   ready_o;
    logic                   done_o;
    logic                   idle_o;
    logic                   overrun_o;
    logic [N_IN*CNT_W-1:0]  in_cnt_o;
    logic [N_OUT*CNT_W-1:0] out_cnt_o;

    modport master (
        output start_i, in_valid_i, in_ready_i, out_valid_i, out_ready_i,
               in_quota_i, out_quota_i,
        input  ready_o, done_o, idle_o, overrun_o, in_cnt_o, out_cnt_o
    );

    modport slave (
        input  start_i, in_valid_i, in_ready_i, out_valid_i, out_ready_i,
               in_quota_i, out_quota_i,
        output ready_o, done_o, idle_o, overrun_o, in_cnt_o, out_cnt_o
    );
endinterface

// File: rtl/multi_dataflow_kernel_tracker.sv
// rtl/multi_dataflow_kernel_tracker.sv - per-stream quota tracker producing engine ready/done/idle flags
module multi_dataflow_kernel_tracker #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    multi_dataflow_kernel_tracker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [N_IN*CNT_W-1:0]  in_quota_q, in_cnt_q;
    logic [N_OUT*CNT_W-1:0] out_quota_q, out_cnt_q;
    logic                   overrun_q;
    logic [N_IN-1:0]        in_xfer, in_full;
    logic [N_OUT-1:0]       out_xfer, out_full;
    logic                   over_hit;

    // Handshake detection and per-stream "quota reached" from registered counters
    always_comb begin
        in_xfer  = bus.in_valid_i & bus.in_ready_i;
        out_xfer = bus.out_valid_i & bus.out_ready_i;
        in_full  = '0;
        out_full = '0;
        for (int k = 0; k < N_IN; k++)
            in_full[k] = (in_cnt_q[k*CNT_W +: CNT_W] == in_quota_q[k*CNT_W +: CNT_W]);
        for (int k = 0; k < N_OUT; k++)
            out_full[k] = (out_cnt_q[k*CNT_W +: CNT_W] == out_quota_q[k*CNT_W +: CNT_W]);
        over_hit = (state_q == RUN) && ((|(in_xfer & in_full)) || (|(out_xfer & out_full)));
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: start always (re)enters RUN; RUN ends once every output stream is complete
    always_comb begin
        state_d = state_q;
        if (bus.start_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = (&out_full) ? DONE : RUN;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Flag decode from registered state and counters
    always_comb begin
        bus.ready_o = (state_q == RUN) && (&in_full);
        bus.done_o  = (state_q == DONE);
        bus.idle_o  = (state_q == IDLE);
    end

    // Quota latch, saturating-at-quota counters and sticky overrun; start beats a coincident transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_quota_q  <= '0;
            out_quota_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            overrun_q   <= 1'b0;
        end else if (bus.start_i) begin
            in_quota_q  <= bus.in_quota_i;
            out_quota_q <= bus.out_quota_i;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            overrun_q   <= 1'b0;
        end else if (state_q == RUN) begin
            for (int k = 0; k < N_IN; k++)
                if (in_xfer[k] && !in_full[k])
                    in_cnt_q[k*CNT_W +: CNT_W] <= in_cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            for (int k = 0; k < N_OUT; k++)
                if (out_xfer[k] && !out_full[k])
                    out_cnt_q[k*CNT_W +: CNT_W] <= out_cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            if (over_hit) overrun_q <= 1'b1;
        end
    end

    assign bus.overrun_o = overrun_q;
    assign bus.in_cnt_o  = in_cnt_q;
    assign bus.out_cnt_o = out_cnt_q;
endmodule

// File: tb/tb_multi_dataflow_kernel_tracker.sv
// tb/tb_multi_dataflow_kernel_tracker.sv - table-driven scoreboard bench for the kernel tracker
module tb_multi_dataflow_kernel_tracker;
    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int CNT_W = 16;

    typedef struct {
        logic        st;
        logic [2:0]  iv, ir;
        logic [1:0]  ov, orr;
        logic        er, ed, ei, eo;
        logic [47:0] eic;
        logic [31:0] eoc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        er, ed, ei, eo;
        logic [47:0] eic;
        logic [31:0] eoc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   row_id = 0;
    vec_t tbl[$];
    exp_t sb[$];

    multi_dataflow_kernel_tracker_if #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) bus ();

    multi_dataflow_kernel_tracker #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pk3(input int s0, input int s1, input int s2);
        return {s2[15:0], s1[15:0], s0[15:0]};
    endfunction

    function automatic logic [31:0] pk2(input int s0, input int s1);
        return {s1[15:0], s0[15:0]};
    endfunction

    task automatic chk(input string name, input int idx, input logic [47:0] act, input logic [47:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [2:0] iv, input logic [2:0] ir,
                       input logic [1:0] ov, input logic [1:0] orr,
                       input logic er, input logic ed, input logic ei, input logic eo,
                       input logic [47:0] eic, input logic [31:0] eoc);
        vec_t v;
        v.st = st; v.iv = iv; v.ir = ir; v.ov = ov; v.orr = orr;
        v.er = er; v.ed = ed; v.ei = ei; v.eo = eo; v.eic = eic; v.eoc = eoc;
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        bus.start_i     = 1'b0;
        bus.in_valid_i  = '0;
        bus.in_ready_i  = '0;
        bus.out_valid_i = '0;
        bus.out_ready_i = '0;
    endtask

    task automatic run_table();
        exp_t e;
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.start_i     = tbl[i].st;
            bus.in_valid_i  = tbl[i].iv;
            bus.in_ready_i  = tbl[i].ir;
            bus.out_valid_i = tbl[i].ov;
            bus.out_ready_i = tbl[i].orr;
            e.idx = row_id; e.er = tbl[i].er; e.ed = tbl[i].ed; e.ei = tbl[i].ei;
            e.eo = tbl[i].eo; e.eic = tbl[i].eic; e.eoc = tbl[i].eoc;
            sb.push_back(e);
            row_id++;
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty (row %0d): got 0 entries expected 1", row_id);
            end else begin
                e = sb.pop_front();
                n_vec++;
                chk("ready_o",   e.idx, 48'(bus.ready_o),   48'(e.er));
                chk("done_o",    e.idx, 48'(bus.done_o),    48'(e.ed));
                chk("idle_o",    e.idx, 48'(bus.idle_o),    48'(e.ei));
                chk("overrun_o", e.idx, 48'(bus.overrun_o), 48'(e.eo));
                chk("in_cnt_o",  e.idx, bus.in_cnt_o,       e.eic);
                chk("out_cnt_o", e.idx, 48'(bus.out_cnt_o), 48'(e.eoc));
            end
        end
        tbl.delete();
        @(negedge clk);
        drive_idle();
    endtask

    task automatic hchk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        chk(name, -1, act, exp);
    endtask

    initial begin
        logic saw_done;
        drive_idle();
        bus.in_quota_i  = '0;
        bus.out_quota_i = '0;
        repeat (2) @(negedge clk);
        hchk("rst_ready", 48'(bus.ready_o), 48'd0);
        hchk("rst_done",  48'(bus.done_o),  48'd0);
        hchk("rst_idle",  48'(bus.idle_o),  48'd1);
        hchk("rst_ovr",   48'(bus.overrun_o), 48'd0);
        hchk("rst_icnt",  bus.in_cnt_o, 48'd0);
        rst = 1'b0;

        // Basic job: in {4,2,1}, out {3,0}
        bus.in_quota_i  = pk3(4, 2, 1);
        bus.out_quota_i = pk2(3, 0);
        add(1, 3'b111, 3'b111, 2'b00, 2'b00, 0, 0, 0, 0, pk3(0,0,0), pk2(0,0));
        add(0, 3'b111, 3'b111, 2'b00, 2'b00, 0, 0, 0, 0, pk3(1,1,1), pk2(0,0));
        add(0, 3'b011, 3'b111, 2'b00, 2'b00, 0, 0, 0, 0, pk3(2,2,1), pk2(0,0));
        add(0, 3'b001, 3'b000, 2'b01, 2'b00, 0, 0, 0, 0, pk3(2,2,1), pk2(0,0));
        add(0, 3'b001, 3'b001, 2'b01, 2'b01, 0, 0, 0, 0, pk3(3,2,1), pk2(1,0));
        add(0, 3'b001, 3'b001, 2'b01, 2'b01, 1, 0, 0, 0, pk3(4,2,1), pk2(2,0));
        add(0, 3'b000, 3'b000, 2'b01, 2'b01, 1, 0, 0, 0, pk3(4,2,1), pk2(3,0));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0, pk3(4,2,1), pk2(3,0));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0, pk3(4,2,1), pk2(3,0));
        add(0, 3'b111, 3'b111, 2'b11, 2'b11, 0, 0, 1, 0, pk3(4,2,1), pk2(3,0));
        run_table();

        // Asynchronous outputs: in all 0, out {5,1}; stream 1 completes first
        bus.in_quota_i  = pk3(0, 0, 0);
        bus.out_quota_i = pk2(5, 1);
        add(1, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 0, pk3(0,0,0), pk2(0,0));
        add(0, 3'b000, 3'b000, 2'b10, 2'b10, 1, 0, 0, 0, pk3(0,0,0), pk2(0,1));
        add(0, 3'b000, 3'b000, 2'b01, 2'b00, 1, 0, 0, 0, pk3(0,0,0), pk2(0,1));
        for (int i = 1; i <= 5; i++)
            add(0, 3'b000, 3'b000, 2'b01, 2'b01, 1, 0, 0, 0, pk3(0,0,0), pk2(i,1));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0, pk3(0,0,0), pk2(5,1));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0, pk3(0,0,0), pk2(5,1));
        run_table();

        // Overrun, restart with coincident transfers, restart from DONE
        bus.in_quota_i  = pk3(2, 5, 5);
        bus.out_quota_i = pk2(1, 0);
        add(1, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, pk3(0,0,0), pk2(0,0));
        add(0, 3'b001, 3'b001, 2'b00, 2'b00, 0, 0, 0, 0, pk3(1,0,0), pk2(0,0));
        add(0, 3'b001, 3'b001, 2'b00, 2'b00, 0, 0, 0, 0, pk3(2,0,0), pk2(0,0));
        add(0, 3'b001, 3'b001, 2'b00, 2'b00, 0, 0, 0, 1, pk3(2,0,0), pk2(0,0));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 1, pk3(2,0,0), pk2(0,0));
        add(1, 3'b001, 3'b001, 2'b01, 2'b01, 0, 0, 0, 0, pk3(0,0,0), pk2(0,0));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, pk3(0,0,0), pk2(0,0));
        add(0, 3'b000, 3'b000, 2'b01, 2'b01, 0, 0, 0, 0, pk3(0,0,0), pk2(1,0));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0, pk3(0,0,0), pk2(1,0));
        add(1, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, pk3(0,0,0), pk2(0,0));
        add(0, 3'b000, 3'b000, 2'b01, 2'b01, 0, 0, 0, 0, pk3(0,0,0), pk2(1,0));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0, pk3(0,0,0), pk2(1,0));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0, pk3(0,0,0), pk2(1,0));
        run_table();

        // Zero quotas: ready on first RUN cycle, done at start+2, idle at start+3
        bus.in_quota_i  = pk3(0, 0, 0);
        bus.out_quota_i = pk2(0, 0);
        add(1, 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 0, 0, pk3(0,0,0), pk2(0,0));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0, pk3(0,0,0), pk2(0,0));
        add(0, 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 1, 0, pk3(0,0,0), pk2(0,0));
        run_table();

        // Asynchronous reset mid-RUN with in_cnt stream 0 at 2
        bus.in_quota_i  = pk3(4, 2, 1);
        bus.out_quota_i = pk2(3, 0);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i    = 1'b0;
        bus.in_valid_i = 3'b001;
        bus.in_ready_i = 3'b001;
        repeat (2) @(negedge clk);
        drive_idle();
        hchk("mid_icnt", bus.in_cnt_o, pk3(2,0,0));
        #1 rst = 1'b1;
        #1;
        hchk("arst_icnt",  bus.in_cnt_o, 48'd0);
        hchk("arst_idle",  48'(bus.idle_o),  48'd1);
        hchk("arst_ready", 48'(bus.ready_o), 48'd0);
        hchk("arst_done",  48'(bus.done_o),  48'd0);
        hchk("arst_ovr",   48'(bus.overrun_o), 48'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.done_o) saw_done = 1'b1;
        end
        hchk("post_rst_no_done", 48'(saw_done), 48'd0);
        hchk("post_rst_idle", 48'(bus.idle_o), 48'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_dataflow_kernel_tracker.md
Name: multi_dataflow_kernel_tracker

Overview:
- Parametrised successor to the single-output kernel adapter flag logic. Monitors N_IN input and N_OUT output stream handshakes around a multi-dataflow reconfigurable datapath.
- Generates ready/done/idle flags for the HWPE engine FSM. Each stream has its own programmable transfer quota, replacing the fixed "one input per ready" rule and the synchronous-outputs restriction.
- Sits between the engine controller and the kernel datapath. Observes handshakes only and never drives valid or ready.

Parameters:
- N_IN, 3, number of monitored input streams (1..16).
- N_OUT, 1, number of monitored output streams (1..16).
- CNT_W, 16, width of per-stream counters and quotas.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  single-cycle start; latches quotas, clears counters.
- in_valid_i  in  N_IN  input stream valid (bit k = stream k).
- in_ready_i  in  N_IN  input stream ready.
- out_valid_i  in  N_OUT  output stream valid.
- out_ready_i  in  N_OUT  output stream ready.
- in_quota_i  in  N_IN*CNT_W  inputs per stream per job; stream k is at bits [k*CNT_W +: CNT_W].
- out_quota_i  in  N_OUT*CNT_W  outputs per stream per job, same packing.
- ready_o  out  1  all input quotas consumed.
- done_o  out  1  one-cycle pulse when all output quotas are reached.
- idle_o  out  1  tracker not running a job.
- overrun_o  out  1  sticky: a transfer occurred beyond its quota.
- in_cnt_o  out  N_IN*CNT_W  live input counters.
- out_cnt_o  out  N_OUT*CNT_W  live output counters.

Behaviour:
- Reset (rst_i high, asynchronous): state IDLE, all counters 0, latched quotas 0.
  - Output values in reset: ready_o=0, done_o=0, idle_o=1, overrun_o=0.
  - Reset mid-job aborts immediately; no done_o pulse is produced.
- Transfer definition: a transfer on stream k is valid & ready high on the same rising edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start_i=1.
  - RUN -> DONE when every output counter equals its latched quota. The check uses registered counters, so it resolves one cycle after the last output transfer.
  - DONE -> IDLE unconditionally after one cycle.
  - start_i in RUN or DONE restarts the job: quotas are re-latched, counters cleared, next state RUN, and done_o is suppressed.
- start_i effects (any state):
  - Latches in_quota_i and out_quota_i.
  - Clears all counters and overrun_o.
  - A transfer coinciding with start_i is not counted; start wins.
- Input counter k (RUN only):
  - Increments on a transfer while below quota.
  - A transfer at quota leaves the counter unchanged and sets overrun_o.
- Output counters follow the same rules as input counters.
- Transfers in IDLE or DONE are ignored: no count, no overrun.
- ready_o: registered; 1 in RUN when all input counters equal their quotas, else 0.
  - Rises one cycle after the completing transfer.
  - Stays high until start_i or leaving RUN.
- done_o: 1 exactly while in DONE, so it is a single-cycle pulse.
- idle_o: 1 in IDLE, 0 in RUN and DONE.
  - Falls the cycle after start_i.
  - Rises the cycle after done_o.
- Zero quota: that stream is complete immediately.
  - All input quotas 0: ready_o=1 on the first RUN cycle.
  - All output quotas 0: RUN lasts one cycle, then DONE.
- Counter arithmetic: unsigned, CNT_W bits, never wraps, because it is bounded by quota ≤ 2^CNT_W−1.
- Simultaneous transfers on multiple streams in one cycle are counted independently, one per stream.
- Latency summary:
  - Handshake to counter update: 1 cycle.
  - Last output transfer to done_o: 2 cycles.

Test Plan:
- Reset check: assert rst_i mid-RUN with in_cnt=2 -> counters 0, idle_o=1, ready_o=0, done_o=0, overrun_o=0 asynchronously; no done pulse after release.
- Basic job (N_IN=3, N_OUT=1): quotas in={4,2,1}, out={3}; drive transfers -> ready_o rises one cycle after the 4th stream-0 input. done_o is a 1-cycle pulse 2 cycles after the 3rd output; idle_o=1 the cycle after.
- Asynchronous outputs (N_OUT=2): out quota {5,1}; stream1 completes first -> no done_o until the 5th stream-0 output; out_cnt_o ends at {5,1}.
- Overrun: in quota {2}; 3 transfers on stream 0 -> in_cnt stays 2, overrun_o=1 and sticky; the next start_i clears it to 0.
- Restart and coincidence: start_i during RUN in the same cycle as an input transfer -> that transfer is not counted, counters are 0, state stays RUN, no done_o.
- Zero quotas: all quotas 0, pulse start_i -> ready_o=1 on the first RUN cycle; done_o at cycle start+2; idle_o back to 1 at start+3.
